// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a show-ahead FIFO and sends each as an 8N1 UART frame
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  input  logic       fifo_busy,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_active,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic tx_n, pop_n, active_n, done_n, bit_end;
  assign bit_end = cnt == LAST;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= 1'b1;
      fifo_pop  <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      tx        <= tx_n;
      fifo_pop  <= pop_n;
      tx_active <= active_n;
      tx_done   <= done_n;
    end
  always_comb begin
    state_n   = state;
    cnt_n     = bit_end ? '0 : cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    tx_n      = tx;
    pop_n     = 1'b0;
    active_n  = tx_active;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        tx_n  = 1'b1;
        cnt_n = '0;
        if (!fifo_empty && !fifo_busy) begin
          shift_n  = fifo_data;
          pop_n    = 1'b1;
          tx_n     = 1'b0;
          active_n = 1'b1;
          state_n  = START;
        end
      end
      START: if (bit_end) begin
        tx_n      = shift[0];
        bit_cnt_n = '0;
        state_n   = DATA;
      end
      // the next line value is the bit that becomes shift[0] after this shift
      DATA: if (bit_end) begin
        shift_n   = shift >> 1;
        bit_cnt_n = bit_cnt + 1'b1;
        tx_n      = bit_cnt == 3'd7 ? 1'b1 : shift[1];
        state_n   = bit_cnt == 3'd7 ? STOP : DATA;
      end
      default: if (bit_end) begin
        active_n = 1'b0;
        done_n   = 1'b1;
        state_n  = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized scoreboard bench; a line-level frame decoder checks every byte sent
module tb_fifo_uart_tx;
  localparam int N = 4;
  logic clock = 0, reset = 0, fifo_busy = 0;
  logic [7:0] fifo_data;
  logic fifo_empty, fifo_pop, tx, tx_active, tx_done;
  int vectors = 0, miscompares = 0, rd = 0, wr = 0, cyc = 0;
  logic [7:0] fmem [0:255];
  logic [7:0] exp_q [$];
  int pop_t [$];
  logic busy_q = 0, empty_q = 1, pop_prev = 0, done_prev = 0, mon_prev = 0, ok;

  assign fifo_empty = rd == wr;
  assign fifo_data  = fmem[rd[7:0]];

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clock(clock), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_busy(fifo_busy), .fifo_pop(fifo_pop), .tx(tx), .tx_active(tx_active), .tx_done(tx_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr[7:0]] = d;
    wr++;
    exp_q.push_back(d);
  endtask

  // behavioural show-ahead FIFO: a registered pop consumes the head on the next edge
  always @(posedge clock) begin
    cyc++;
    busy_q  <= fifo_busy;
    empty_q <= fifo_empty;
    if (fifo_pop) begin
      rd <= rd + 1;
      pop_t.push_back(cyc);
    end
  end

  always @(negedge clock)
    if (!reset) begin
      if (fifo_pop) begin
        chk("pop_gate", {busy_q, empty_q}, 0);
        chk("pop_line", {tx, tx_active}, 2'b01);
        chk("pop_width", pop_prev, 0);
      end
      if (tx_done) chk("done_width", done_prev, 0);
      if (!tx_active) chk("idle_line", tx, 1);
      pop_prev  = fifo_pop;
      done_prev = tx_done;
    end

  task automatic frame_chk();
    logic [9:0] bits;
    logic [7:0] e;
    bit line_ok = 1, act_ok = 1;
    e = 0;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_expected: frame started with no byte queued at %0t", $time);
    end else e = exp_q.pop_front();
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < N; c++) begin
        if (b != 0 || c != 0) @(negedge clock);
        if (reset) return;
        if (!tx_active) act_ok = 0;
        if (c == 0) bits[b] = tx;
        else if (tx != bits[b]) line_ok = 0;
      end
    @(negedge clock);
    if (reset) return;
    chk("start_bit", bits[0], 0);
    chk("data", bits[8:1], e);
    chk("stop_bit", bits[9], 1);
    chk("bit_hold", line_ok, 1);
    chk("active_len", {act_ok, tx_active}, 2'b10);
    chk("done_pulse", tx_done, 1);
  endtask

  initial
    forever begin
      @(negedge clock);
      if (!reset && tx_active && !mon_prev) frame_chk();
      mon_prev = tx_active;
    end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(exp_q.size() == 0 && rd == wr && !tx_active) && n < budget);
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: not idle after %0d cycles", budget);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #1 reset = 1;
    #1 chk("reset_init", {tx, fifo_pop, tx_active, tx_done}, 4'b1000);
    repeat (2) @(negedge clock);
    reset = 0;
    push(8'hF1);
    wait_idle(200);
    pop_t.delete();
    push(8'hFA);
    push(8'h91);
    wait_idle(300);
    chk("b2b_pops", pop_t.size(), 2);
    if (pop_t.size() == 2) chk("b2b_gap", pop_t[1] - pop_t[0], 10 * N + 1);
    fifo_busy = 1;
    push(8'h3C);
    ok = 1;
    repeat (10) begin
      @(negedge clock);
      if (fifo_pop || !tx) ok = 0;
    end
    chk("busy_hold", ok, 1);
    fifo_busy = 0;
    @(negedge clock);
    chk("busy_release", {fifo_pop, tx}, 2'b10);
    wait_idle(200);
    push(8'hF1);
    repeat (20) @(negedge clock);
    #2 reset = 1;
    #1 chk("reset_async", {tx, fifo_pop, tx_active, tx_done}, 4'b1000);
    repeat (2) @(negedge clock);
    reset = 0;
    ok = 1;
    repeat (5) begin
      @(negedge clock);
      if (tx_done || tx_active || !tx) ok = 0;
    end
    chk("reset_drop", ok, 1);
    push(8'hFA);
    wait_idle(200);
    for (int i = 0; i < 24; i++) begin
      push(8'($urandom));
      repeat ($urandom_range(0, 50)) begin
        @(negedge clock);
        fifo_busy = $urandom_range(0, 3) == 0;
      end
    end
    fifo_busy = 0;
    wait_idle(3000);
    chk("fifo_drained", wr - rd, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that sits directly downstream of the 8-bit `fifo`. Whenever the FIFO holds data and is not busy, it pops one byte and sends it on `tx` as an 8N1 UART frame (start bit, 8 data bits LSB first, one stop bit). Transmission continues until the FIFO is empty. It is the FPGA's outbound serial path for buffered bytes.

## Interface

- `CLKS_PER_BIT`, default 868, is the number of `clock` cycles per serial bit (100 MHz / 115200). Legal range is 2..65535.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_data`  in  8  head byte from `fifo.data_out`; valid while `fifo_empty`=0.
- `fifo_empty`  in  1  from `fifo.empty`.
- `fifo_busy`  in  1  from `fifo.busy`; no pop is issued while it is high.
- `fifo_pop`  out  1  to `fifo.pop`; a registered single-cycle pulse.
- `tx`  out  1  serial line, idle high.
- `tx_active`  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- `tx_done`  out  1  one-cycle pulse after each completed frame.

## Operation

- Reset values (asynchronous, immediate):
  - `tx`=1, `fifo_pop`=0, `tx_active`=0, `tx_done`=0
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0
- FIFO contract: `fifo_data` shows the head byte whenever `fifo_empty`=0 (show-ahead). A one-cycle `fifo_pop` consumes that byte.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1.
  - If `fifo_empty`=0 and `fifo_busy`=0 at a rising edge, then on that edge:
    - latch `fifo_data` into the shift register;
    - set `fifo_pop`=1, `tx`=0, `tx_active`=1;
    - clear the cycle counter;
    - go to START.
  - Otherwise stay in IDLE.
- `fifo_pop` returns to 0 on the next edge unconditionally. It is never high for two consecutive cycles.
- START:
  - `tx`=0 for `CLKS_PER_BIT` cycles.
  - Then set `tx`=shift[0], clear the bit counter, go to DATA.
- DATA:
  - Each bit is held for `CLKS_PER_BIT` cycles.
  - At the end of a bit: shift right and increment the bit counter.
  - After bit 7: set `tx`=1 and go to STOP.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - Then set `tx_active`=0, pulse `tx_done`=1 for one cycle, go to IDLE.
- The cycle counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at every bit boundary.
- The bit counter is 3 bits wide, range 0..7.
- Inputs are ignored outside IDLE. A FIFO push during a frame does not affect the current frame.

## Timing

- Pop-to-line latency: `fifo_pop` and the falling edge of `tx` (start bit) appear on the same clock edge.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles of `tx_active`=1.
- `tx_done` is asserted in the first IDLE cycle after STOP.
- Back-to-back bytes: if the FIFO is non-empty at that same IDLE edge, the next pop and start bit occur on it. The frame period is therefore 10×`CLKS_PER_BIT`+1 cycles, giving one extra idle-high cycle between frames.
- Boundary conditions:
  - Empty after a pop: the block returns to IDLE and holds `tx`=1 indefinitely.
  - `fifo_busy`=1 with data present: the pop is deferred; the start bit begins on the first edge where `fifo_busy`=0.
  - `fifo_empty` deasserts and `fifo_busy` asserts in the same cycle: no pop.
  - Reset mid-frame: `tx` goes to 1 immediately and the in-flight byte is dropped. It is not re-popped, and no `tx_done` pulse is produced.
  - Reset during the `fifo_pop` cycle: `fifo_pop` is forced low immediately.

## Test plan

- **Reset.** Assert `reset` mid-operation, `CLKS_PER_BIT`=4. Required: `tx`=1, `fifo_pop`=0, `tx_active`=0, `tx_done`=0 without waiting for a clock edge.
- **Single byte.** FIFO holds 0xF1, `CLKS_PER_BIT`=4. Required:
  - one `fifo_pop` pulse;
  - `tx` sequence 0,1,0,0,0,1,1,1,1,1, each bit held 4 cycles;
  - `tx_active` high for 40 cycles;
  - one `tx_done` pulse;
  - then idle high.
- **Back-to-back.** FIFO holds 0xFA then 0x91. Required:
  - two pops 41 cycles apart;
  - data bits 0,1,0,1,1,1,1,1 then 1,0,0,0,1,0,0,1;
  - exactly one idle-high cycle between the two stop bits and the second start bit.
- **Busy hold-off.** `fifo_busy`=1 for 10 cycles with data present. Required: no pop and `tx`=1 throughout; the pop and start bit occur on the first edge with `fifo_busy`=0.
- **Reset mid-frame.** Assert `reset` during DATA of 0xF1. Required: `tx`=1 immediately and no `tx_done`. After release with the FIFO holding 0xFA, the next frame carries 0xFA.
- **FIFO integration.** Connect to `fifo` and push 0xF1, 0xFA, 0x91. Required: the three frames are sent in order, `fifo.data_count` ends at 0, and `fifo_pop` is never asserted while `empty`=1.
